bram_block_streamer: RTL and testbench

- Downstream consumer of the dual-port block BRAM wrapper's read side. Issues one read request per block, absorbs the fixed 2-cycle BRAM latency, and presents the blocks of one big-number operand as a valid/ready stream to the modular-arithmetic stages.
- Credit-based issue guarantees no returned block is ever dropped under backpressure.

---
 rtl/bram_stream_pkg.sv | 18 +
 rtl/block_fwft_fifo.sv | 63 ++++++
 rtl/bram_block_streamer.sv | 132 +++++++++++++
 tb/tb_bram_block_streamer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared types and constants for the BRAM block streamer
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } stream_state_t;

  localparam int BRAM_READ_LATENCY = 2;

  // Counters must be able to hold the value n itself, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/block_fwft_fifo.sv
// rtl/block_fwft_fifo.sv - first-word-fall-through return buffer for BRAM blocks
module block_fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    count    = count_q;
    rdata    = mem_q[rd_ptr_q];
    // A full buffer can still take a word when the head leaves in the same cycle.
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bram_block_streamer.sv
// rtl/bram_block_streamer.sv - credit-based BRAM operand reader presenting blocks as a valid/ready stream
// Optional running sum of transferred beats on checksum_out when BLOCK_STREAMER_CHECKSUM_EN is defined.
module bram_block_streamer
  import bram_stream_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic                     busy_out,
  output logic                     read_next_block_out,
  input  logic [REGISTER_SIZE-1:0] read_block_in,
  input  logic                     read_block_valid_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     last_out,
  output logic                     done_out
`ifdef BLOCK_STREAMER_CHECKSUM_EN
  ,
  output logic [REGISTER_SIZE-1:0] checksum_out
`endif
);

  localparam int CNT_W = cnt_width(NUM_BLOCKS);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] NB       = CNT_W'(NUM_BLOCKS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BLOCKS - 1);
  localparam logic [FC_W:0]    CREDITS  = (FC_W + 1)'(FIFO_DEPTH);

  stream_state_t state_q, state_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [FC_W-1:0]  inflight_q, inflight_d;

  logic [FC_W-1:0]          fifo_count;
  logic [REGISTER_SIZE-1:0] fifo_rdata;
  logic fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic start_accept, ret_accept, credit_ok, issue, beat;

  block_fwft_fifo #(
    .WIDTH(REGISTER_SIZE),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (fifo_push),
    .wdata  (read_block_in),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_comb begin
    valid_out    = !fifo_empty;
    data_out     = valid_out ? fifo_rdata : '0;
    beat         = valid_out && ready_in;
    fifo_pop     = beat;
    last_out     = valid_out && (sent_cnt_q == LAST_IDX);
    busy_out     = (state_q != IDLE);
    done_out     = (state_q == DONE);
    start_accept = (state_q == IDLE) && start_in;
    // A return with nothing outstanding is spurious and must not eat a credit.
    ret_accept   = read_block_valid_in && (inflight_q != '0);
    fifo_push    = ret_accept && !fifo_full;
    // Every outstanding request owns a FIFO slot, so a return can never overflow.
    credit_ok    = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CREDITS;
    issue        = (state_q == ISSUE) && (issued_cnt_q != NB) && credit_ok;
    read_next_block_out = issue;

    issued_cnt_d = start_accept ? '0 : issued_cnt_q + CNT_W'(issue);
    sent_cnt_d   = start_accept ? '0 : sent_cnt_q + CNT_W'(beat);

    inflight_d = inflight_q;
    case ({issue, ret_accept})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = ISSUE;
      ISSUE:   if (issued_cnt_d == NB) state_d = DRAIN;
      DRAIN:   if (beat && last_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      issued_cnt_q <= '0;
      sent_cnt_q   <= '0;
      inflight_q   <= '0;
    end else begin
      state_q      <= state_d;
      issued_cnt_q <= issued_cnt_d;
      sent_cnt_q   <= sent_cnt_d;
      inflight_q   <= inflight_d;
    end
  end

`ifdef BLOCK_STREAMER_CHECKSUM_EN
  logic [REGISTER_SIZE-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) begin
      checksum_d = '0;
    end else if (beat) begin
      checksum_d = checksum_q + data_out;
    end
    checksum_out = checksum_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end
`endif

endmodule

// File: tb/tb_bram_block_streamer.sv
// tb/tb_bram_block_streamer.sv - randomized self-checking bench for bram_block_streamer
module tb_bram_block_streamer;
  import bram_stream_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = BRAM_READ_LATENCY;

  logic        clk = 1'b0;
  logic        rst_in, start_in, ready_in;
  logic        busy_out, read_next_block_out, valid_out, last_out, done_out;
  logic [31:0] read_block_in, data_out;
  logic        read_block_valid_in;
`ifdef BLOCK_STREAMER_CHECKSUM_EN
  logic [31:0] checksum_out;
`endif

  always #5 clk = ~clk;

  bram_block_streamer #(
    .REGISTER_SIZE(32),
    .NUM_BLOCKS(NB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst_in),
    .start_in            (start_in),
    .busy_out            (busy_out),
    .read_next_block_out (read_next_block_out),
    .read_block_in       (read_block_in),
    .read_block_valid_in (read_block_valid_in),
    .data_out            (data_out),
    .valid_out           (valid_out),
    .ready_in            (ready_in),
    .last_out            (last_out),
    .done_out            (done_out)
`ifdef BLOCK_STREAMER_CHECKSUM_EN
    ,
    .checksum_out        (checksum_out)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  // BRAM model: fixed-latency read pipe with an address that wraps every NB requests.
  logic [31:0] mem [NB];
  logic        pv [LAT];
  logic [31:0] pd [LAT];
  int          bram_addr;

  assign read_block_valid_in = pv[LAT-1];
  assign read_block_in       = pd[LAT-1];

  always @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
      bram_addr <= 0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= read_next_block_out;
      pd[0] <= mem[bram_addr];
      if (read_next_block_out) bram_addr <= (bram_addr + 1) % NB;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model state.
  logic        in_op = 1'b0, done_due = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0, tb_sum = '0;
  int          exp_idx = 0, occ = 0, infl = 0, req_cnt_op = 0;
  logic        accept, old_done, nxt_done, xfer;

  // Observations for the main sequence.
  int first_req, last_req, first_valid, last_cyc, done_cyc, busy_cnt, req_cnt, beats, dones;
  int done_cnt = 0;
  logic        done_seen;
  logic [31:0] first_data, done_ck;

  always @(negedge clk) begin
    if (rst_in) begin
      in_op = 1'b0; done_due = 1'b0; exp_idx = 0; occ = 0; prev_stall = 1'b0; req_cnt_op = 0;
    end else begin
      accept   = !in_op && start_in;
      old_done = done_due;
      nxt_done = 1'b0;
      xfer     = valid_out && ready_in;
      check("busy", busy_out, in_op);
      check("done", done_out, done_due);
      check("valid_vs_occupancy", valid_out, occ != 0);
      check("last", last_out, valid_out && (exp_idx == NB - 1));
      infl = 0;
      for (int i = 0; i < LAT; i++) infl += int'(pv[i]);
      check("credit", (infl + occ + int'(read_next_block_out)) <= DEPTH, 1);
      if (!in_op) check("idle_no_req", read_next_block_out, 0);
      if (prev_stall) begin
        check("hold_valid", valid_out, 1);
        check("hold_data", data_out, prev_data);
        check("hold_last", last_out, prev_last);
      end
      if (read_next_block_out) begin
        req_cnt++; req_cnt_op++;
        if (first_req < 0) first_req = cyc;
        last_req = cyc;
      end
      if (busy_out) busy_cnt++;
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (done_out) begin
        done_cnt++; dones++; done_seen = 1'b1; done_cyc = cyc;
        check("req_per_op", req_cnt_op, NB);
`ifdef BLOCK_STREAMER_CHECKSUM_EN
        check("checksum_model", checksum_out, tb_sum);
        done_ck = checksum_out;
`endif
      end
      if (xfer) begin
        if (exp_idx < NB) begin
          check("data", data_out, mem[exp_idx]);
          if (exp_idx == 0) first_data = data_out;
        end else begin
          check("extra_beat", exp_idx, NB - 1);
        end
        if (last_out) last_cyc = cyc;
        tb_sum = tb_sum + data_out;
        beats++;
        exp_idx++;
        if (exp_idx == NB) nxt_done = 1'b1;
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      prev_last  = last_out;
      occ = occ + int'(read_block_valid_in) - int'(xfer);
      if (old_done) in_op = 1'b0;
      done_due = nxt_done;
      if (accept) begin
        check("addr_at_start", bram_addr, 0);
        in_op = 1'b1; exp_idx = 0; tb_sum = '0; req_cnt_op = 0;
      end
    end
  end

  logic rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_stats();
    first_req = -1; last_req = -1; first_valid = -1; last_cyc = -1; done_cyc = -1;
    busy_cnt = 0; req_cnt = 0; beats = 0; dones = 0; done_seen = 1'b0; first_data = '0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    check(nm, done_seen, 1);
  endtask

  task automatic load_mem(input logic [31:0] base, input logic incr);
    for (int i = 0; i < NB; i++) mem[i] = incr ? 32'(base * (i + 1)) : base;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int T, d0;

  initial begin
    rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b0;
    load_mem(32'h11, 1'b1);
    clear_stats();
    repeat (3) tick();
    rst_in = 1'b0;
    check("rst_busy", busy_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_last", last_out, 0);
    check("rst_done", done_out, 0);
    check("rst_req", read_next_block_out, 0);

    // Unthrottled operand: pinned latency and timing.
    ready_in = 1'b1;
    while (cyc < 10) tick();
    clear_stats();
    T = cyc;
    pulse_start();
    wait_done(50, "t1_done_timeout");
    tick();
    check("t1_first_req", first_req, T + 1);
    check("t1_last_req", last_req, T + 4);
    check("t1_first_valid", first_valid, T + 4);
    check("t1_last_cycle", last_cyc, T + 7);
    check("t1_done_cycle", done_cyc, T + 8);
    check("t1_busy_cycles", busy_cnt, 8);
    check("t1_req_count", req_cnt, 4);
    check("t1_first_data", first_data, 32'h11);

    // Held backpressure: credits cap issue at the buffer depth.
    ready_in = 1'b0;
    clear_stats();
    pulse_start();
    repeat (20) tick();
    check("t2_req_count", req_cnt, 4);
    check("t2_beats_stalled", beats, 0);
    ready_in = 1'b1;
    wait_done(50, "t2_done_timeout");
    tick();
    check("t2_beats", beats, 4);

    // Random ready over many back-to-back operands.
    rand_ready = 1'b1;
    d0 = done_cnt;
    for (int op = 0; op < 100; op++) begin
      clear_stats();
      pulse_start();
      wait_done(300, "t3_done_timeout");
    end
    rand_ready = 1'b0;
    ready_in = 1'b1;
    tick();
    check("t3_operands", done_cnt - d0, 100);

    // Reset in DRAIN with two beats still buffered.
    ready_in = 1'b0;
    clear_stats();
    pulse_start();
    repeat (10) tick();
    ready_in = 1'b1;
    tick();
    tick();
    ready_in = 1'b0;
    check("t4_beats_before_rst", beats, 2);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("t4_rst_busy", busy_out, 0);
    check("t4_rst_valid", valid_out, 0);
    check("t4_rst_data", data_out, 0);
    check("t4_rst_last", last_out, 0);
    check("t4_rst_done", done_out, 0);
    check("t4_rst_req", read_next_block_out, 0);
    ready_in = 1'b1;
    clear_stats();
    pulse_start();
    wait_done(50, "t4_done_timeout");
    tick();
    check("t4_first_data", first_data, 32'h11);
    check("t4_beats", beats, 4);

    // Start pulsed while busy is ignored.
    clear_stats();
    pulse_start();
    tick();
    tick();
    pulse_start();
    wait_done(50, "t5_done_timeout");
    repeat (20) tick();
    check("t5_beats", beats, 4);
    check("t5_dones", dones, 1);

    // Wrap-around data and the optional running sum.
    clear_stats();
    pulse_start();
    wait_done(50, "t6a_done_timeout");
    tick();
`ifdef BLOCK_STREAMER_CHECKSUM_EN
    check("t6_checksum_aa", done_ck, 32'hAA);
`endif
    load_mem(32'hFFFF_FFFF, 1'b0);
    clear_stats();
    pulse_start();
    wait_done(50, "t6b_done_timeout");
    tick();
    check("t6_first_data_ff", first_data, 32'hFFFF_FFFF);
`ifdef BLOCK_STREAMER_CHECKSUM_EN
    check("t6_checksum_fffc", done_ck, 32'hFFFF_FFFC);
`endif
    load_mem(32'h11, 1'b1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
